// File: rtl/hw_sw_comm_pkg.sv
// Shared types and handshake codes for the CPU-to-hardware
// command message path.
package hw_sw_comm_pkg;

   typedef enum logic [2:0] {
      S_RESET,
      S_IDLE,
      S_BUSY,
      S_CAPTURE,
      S_VERIFY,
      S_ACK,
      S_NAK,
      S_RELEASE
   } state_t;

   localparam logic [1:0] HW_IDLE = 2'd0;
   localparam logic [1:0] HW_SEEN = 2'd1;
   localparam logic [1:0] HW_REQ  = 2'd3;

   localparam logic [1:0] SW_IDLE = 2'd0;
   localparam logic [1:0] SW_BUSY = 2'd1;
   localparam logic [1:0] SW_NAK  = 2'd2;
   localparam logic [1:0] SW_ACK  = 2'd3;

   localparam int MSG_BYTES = 10;

   typedef struct packed {
      logic [7:0]  mtype;
      logic [63:0] data;
   } msg_t;

   // XOR of every byte except the trailing checksum byte
   function automatic logic [7:0] msg_xor(
      input logic [8*MSG_BYTES-1:0] b
   );
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < MSG_BYTES - 1; i++) begin
         s = s ^ b[8*i +: 8];
      end
      return s;
   endfunction

endpackage

// File: rtl/msg_fifo.sv
// Small message FIFO with a registered head entry so the
// consumer sees the oldest message straight from a flop.
import hw_sw_comm_pkg::*;

module msg_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = msg_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T             mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_nxt  = rd_ptr + AW'(do_pop);

   // Storage array; only slots behind the head are ever read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and the head register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_nxt;
         cnt    <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
         if (do_push && (wr_ptr == rd_nxt)) begin
            head <= din;
         end else if (do_pop && (cnt > (AW+1)'(1))) begin
            head <= mem[rd_nxt];
         end
      end
   end

endmodule

// File: rtl/sw_msg_receiver.sv
// Receives checksummed 10-byte CPU command messages over a
// 4-phase PIO handshake and queues good ones for game logic.
import hw_sw_comm_pkg::*;

module sw_msg_receiver #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  to_hw_sig,
   input  logic [7:0]  to_hw_port0,
   input  logic [7:0]  to_hw_port1,
   input  logic [7:0]  to_hw_port2,
   input  logic [7:0]  to_hw_port3,
   input  logic [7:0]  to_hw_port4,
   input  logic [7:0]  to_hw_port5,
   input  logic [7:0]  to_hw_port6,
   input  logic [7:0]  to_hw_port7,
   input  logic [7:0]  to_hw_port8,
   input  logic [7:0]  to_hw_port9,
   output logic [1:0]  to_sw_sig,
   output logic        msg_valid,
   input  logic        msg_ready,
   output logic [7:0]  msg_type,
   output logic [63:0] msg_data,
   output logic [15:0] msg_count,
   output logic [7:0]  err_count
);

   state_t                     state;
   logic [8*MSG_BYTES-1:0]     stg;
   logic                       cs_ok;
   logic                       push;
   logic                       pop;
   logic                       full;
   logic                       empty;
   msg_t                       din;
   msg_t                       head;

   assign cs_ok     = (msg_xor(stg) == stg[8*MSG_BYTES-1 -: 8]);
   assign push      = (state == S_VERIFY) && cs_ok;
   assign din       = '{mtype: stg[7:0], data: stg[71:8]};
   assign msg_valid = !empty;
   assign pop       = msg_valid && msg_ready;
   assign msg_type  = head.mtype;
   assign msg_data  = head.data;

   msg_fifo #(
      .DEPTH (DEPTH),
      .T     (msg_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   // Handshake code seen by the CPU, decoded from the state
   always_comb begin
      to_sw_sig = SW_IDLE;
      unique case (1'b1)
         (state == S_BUSY): to_sw_sig = SW_BUSY;
         (state == S_ACK):  to_sw_sig = SW_ACK;
         (state == S_NAK):  to_sw_sig = SW_NAK;
         default:           to_sw_sig = SW_IDLE;
      endcase
   end

   // Handshake FSM, staging register, checksum result counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_RESET;
         stg       <= '0;
         msg_count <= '0;
         err_count <= '0;
      end else begin
         case (state)
            S_RESET: state <= S_IDLE;
            S_IDLE: begin
               if (to_hw_sig == HW_REQ) begin
                  state <= full ? S_BUSY : S_CAPTURE;
               end
            end
            S_BUSY: begin
               if (!full) begin
                  state <= S_CAPTURE;
               end else if (to_hw_sig == HW_IDLE) begin
                  state <= S_IDLE;
               end
            end
            S_CAPTURE: begin
               stg <= {to_hw_port9, to_hw_port8,
                       to_hw_port7, to_hw_port6,
                       to_hw_port5, to_hw_port4,
                       to_hw_port3, to_hw_port2,
                       to_hw_port1, to_hw_port0};
               state <= S_VERIFY;
            end
            S_VERIFY: begin
               if (cs_ok) begin
                  msg_count <= msg_count + 16'd1;
                  state     <= S_ACK;
               end else begin
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
                  state <= S_NAK;
               end
            end
            S_ACK, S_NAK: begin
               if (to_hw_sig == HW_SEEN) begin
                  state <= S_RELEASE;
               end else if (to_hw_sig == HW_IDLE) begin
                  state <= S_IDLE;
               end
            end
            S_RELEASE: begin
               if (to_hw_sig == HW_IDLE) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sw_msg_receiver.sv
// Scoreboard bench for sw_msg_receiver: directed handshake
// cases followed by randomized traffic.
module tb_sw_msg_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  to_hw_sig;
   logic [7:0]  port [10];
   logic [1:0]  to_sw_sig;
   logic        msg_valid;
   logic        msg_ready;
   logic [7:0]  msg_type;
   logic [63:0] msg_data;
   logic [15:0] msg_count;
   logic [7:0]  err_count;

   int tests = 0;
   int fails = 0;

   logic [71:0] exp_q [$];
   logic [15:0] mcount;
   logic [7:0]  ecount;
   bit          rand_ready = 0;
   bit          ready_force = 0;

   sw_msg_receiver #(.DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .to_hw_sig   (to_hw_sig),
      .to_hw_port0 (port[0]),
      .to_hw_port1 (port[1]),
      .to_hw_port2 (port[2]),
      .to_hw_port3 (port[3]),
      .to_hw_port4 (port[4]),
      .to_hw_port5 (port[5]),
      .to_hw_port6 (port[6]),
      .to_hw_port7 (port[7]),
      .to_hw_port8 (port[8]),
      .to_hw_port9 (port[9]),
      .to_sw_sig   (to_sw_sig),
      .msg_valid   (msg_valid),
      .msg_ready   (msg_ready),
      .msg_type    (msg_type),
      .msg_data    (msg_data),
      .msg_count   (msg_count),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [71:0] act,
                      input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Consumer ready, changed just after the rising edge
   initial begin
      msg_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         msg_ready = rand_ready ? 1'($urandom_range(0, 1))
                                : ready_force;
      end
   end

   // Monitor: head stability and in-order delivery
   logic        hold = 1'b0;
   logic [71:0] held;
   always @(negedge clk) begin
      if (reset) begin
         hold = 1'b0;
      end else begin
         if (hold && msg_valid)
            chk("head_stable", {msg_type, msg_data}, held);
         if (msg_valid && msg_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_unexpected: got %h expected none",
                        {msg_type, msg_data});
            end else begin
               chk("pop_order", {msg_type, msg_data}, exp_q.pop_front());
            end
         end
         hold = msg_valid && !msg_ready;
         held = {msg_type, msg_data};
      end
   end

   function automatic logic [7:0] xsum(input logic [79:0] m);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 9; i++) s ^= m[8*i +: 8];
      return s;
   endfunction

   function automatic logic [79:0] mk(input bit good);
      logic [79:0] m;
      for (int i = 0; i < 9; i++) m[8*i +: 8] = 8'($urandom);
      m[79:72] = xsum(m) ^ (good ? 8'h00 : 8'($urandom_range(1, 255)));
      return m;
   endfunction

   task automatic req(input logic [79:0] m, input bit rec);
      @(negedge clk);
      for (int i = 0; i < 10; i++) port[i] = m[8*i +: 8];
      to_hw_sig = 2'd3;
      if (rec) begin
         if (xsum(m) == m[79:72]) begin
            exp_q.push_back({m[7:0], m[71:8]});
            mcount = mcount + 16'd1;
         end else if (ecount != 8'hFF) begin
            ecount = ecount + 8'd1;
         end
      end
   endtask

   task automatic wait_code(input logic [1:0] code, input string nm);
      int n = 0;
      while (to_sw_sig != 2'd2 && to_sw_sig != 2'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(nm, to_sw_sig, code);
      chk("msg_count", msg_count, mcount);
      chk("err_count", err_count, ecount);
   endtask

   task automatic finish_hs(input bit abort);
      if (abort) begin
         to_hw_sig = 2'd0;
         @(negedge clk);
         chk("abort_idle", to_sw_sig, 2'd0);
      end else begin
         to_hw_sig = 2'd1;
         @(negedge clk);
         chk("release_sig", to_sw_sig, 2'd0);
         to_hw_sig = 2'd0;
         @(negedge clk);
         chk("idle_sig", to_sw_sig, 2'd0);
      end
   endtask

   task automatic drain();
      int n = 0;
      ready_force = 1;
      while ((exp_q.size() != 0 || msg_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      ready_force = 0;
      chk("drain_queue", 72'(exp_q.size()), 72'd0);
      @(negedge clk);
      @(negedge clk);
      chk("drain_valid", msg_valid, 1'b0);
   endtask

   task automatic send(input logic [79:0] m);
      bit good;
      good = (xsum(m) == m[79:72]);
      req(m, 1);
      wait_code(good ? 2'd3 : 2'd2, good ? "ack" : "nak");
      finish_hs(0);
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_sig"}, to_sw_sig, 2'd0);
      chk({nm, "_valid"}, msg_valid, 1'b0);
      chk({nm, "_type"}, msg_type, 8'h00);
      chk({nm, "_data"}, msg_data, 64'h0);
      chk({nm, "_mcnt"}, msg_count, 16'h0);
      chk({nm, "_ecnt"}, err_count, 8'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [79:0] m;
      reset     = 1'b1;
      to_hw_sig = 2'd0;
      for (int i = 0; i < 10; i++) port[i] = 8'h00;
      mcount = 16'd0;
      ecount = 8'd0;
      repeat (2) @(negedge clk);
      check_reset("rst");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Known-good message and its exact timing
      m = 80'h0D_08_07_06_05_04_03_02_01_05;
      req(m, 1);
      @(negedge clk);
      chk("capture_sig", to_sw_sig, 2'd0);
      @(negedge clk);
      chk("verify_sig", to_sw_sig, 2'd0);
      chk("verify_valid", msg_valid, 1'b0);
      @(negedge clk);
      chk("ack_timing", to_sw_sig, 2'd3);
      chk("valid_after_push", msg_valid, 1'b1);
      chk("dir_type", msg_type, 8'h05);
      chk("dir_data", msg_data, 64'h0807060504030201);
      chk("dir_mcount", msg_count, 16'd1);
      finish_hs(0);

      // Same payload, broken checksum
      m[79:72] = 8'h00;
      req(m, 1);
      wait_code(2'd2, "bad_nak");
      chk("bad_head_kept", msg_type, 8'h05);
      finish_hs(0);
      drain();
      chk("bad_no_valid", msg_valid, 1'b0);

      // Fill the FIFO, then a fifth request waits in BUSY
      repeat (4) send(mk(1));
      req(mk(1), 1);
      repeat (3) begin
         @(negedge clk);
         chk("busy_sig", to_sw_sig, 2'd1);
      end
      ready_force = 1;
      @(negedge clk);
      @(negedge clk);
      ready_force = 0;
      wait_code(2'd3, "busy_then_ack");
      finish_hs(0);
      drain();

      // Withdraw while BUSY
      repeat (4) send(mk(1));
      req(mk(1), 0);
      @(negedge clk);
      chk("busy_abort_pre", to_sw_sig, 2'd1);
      finish_hs(1);
      @(negedge clk);
      chk("busy_abort_cnt", msg_count, mcount);
      drain();

      // Withdraw while in ACK: the message stays queued
      req(mk(1), 1);
      wait_code(2'd3, "ack_abort_pre");
      finish_hs(1);
      @(negedge clk);
      chk("ack_abort_kept", msg_valid, 1'b1);

      // Reset while VERIFY with two messages queued
      send(mk(1));
      req(mk(1), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset("midrst");
      exp_q.delete();
      mcount = 16'd0;
      ecount = 8'd0;
      to_hw_sig = 2'd0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset("postrst");

      // Error counter saturation
      repeat (256) send(mk(0));
      chk("err_sat", err_count, 8'd255);

      // Random traffic with a random consumer
      rand_ready = 1;
      for (int k = 0; k < 60; k++) begin
         bit good;
         bit ab;
         good = ($urandom_range(0, 3) != 0);
         ab   = ($urandom_range(0, 5) == 0);
         req(mk(good), 1);
         wait_code(good ? 2'd3 : 2'd2, "rand_resp");
         finish_hs(ab);
      end
      rand_ready = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
